// File: rtl/sbd_fifo_mw.sv
// sbd_fifo_mw: multi-port scoreboard FIFO.
// Records, in program order, the pipeline (one-hot pl) and PC of each issued
// instruction. It accepts up to NumWr issue-slot entries and retires up to
// NumRd commit-slot entries per cycle. It adds flush, occupancy reporting and a
// sticky protocol-error flag.
//
// Occupancy is held in an explicit count. The pointers are therefore plain
// modulo-Depth indices with no wrap bit.
module sbd_fifo_mw #(
    parameter int Depth = 8,
    parameter int NumWr = 2,
    parameter int NumRd = 2,
    parameter int PlW   = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [NumWr-1:0]           wr_valid_i,
    input  logic [NumWr*PlW-1:0]       wr_pl_i,
    input  logic [NumWr*32-1:0]        wr_pc_i,
    output logic                       wr_ready_o,
    output logic [NumRd-1:0]           rd_valid_o,
    output logic [NumRd*PlW-1:0]       rd_pl_o,
    output logic [NumRd*32-1:0]        rd_pc_o,
    input  logic [NumRd-1:0]           rd_ack_i,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       proto_err_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    // Storage is deliberately not reset; read data is only meaningful under rd_valid_o.
    logic [PlW-1:0] mem_pl [Depth];
    logic [31:0]    mem_pc [Depth];

    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           proto_err;

    // Write-side decode.
    logic           wr_ready;
    logic           wr_any;
    logic           wr_en;
    logic           wr_err;
    logic [CW-1:0]  n_wr;
    logic [AW-1:0]  wr_addr [NumWr];

    // Read-side decode.
    logic [NumRd-1:0] rd_valid;
    logic [AW-1:0]    rd_addr [NumRd];
    logic             ack_any;
    logic             ack_therm;
    logic             ack_legal;
    logic             pop_en;
    logic             ack_err;
    logic [CW-1:0]    n_pop;

    // Write decode: space check, popcount and compaction of valid ports onto consecutive slots.
    always_comb begin
        logic [CW-1:0] off;
        wr_ready = ((CW'(Depth) - count) >= CW'(NumWr));
        wr_any   = |wr_valid_i;
        wr_en    = wr_any && wr_ready && !flush_i;
        wr_err   = wr_any && !wr_ready && !flush_i;
        n_wr     = '0;
        off      = '0;
        for (int k = 0; k < NumWr; k++) begin
            // Each valid port lands at wr_ptr plus the number of valid ports below it.
            wr_addr[k] = wr_ptr + AW'(off);
            off        = off + CW'(wr_valid_i[k]);
            n_wr       = n_wr + CW'(wr_valid_i[k]);
        end
    end

    // Read decode: thermometer valids, head addresses and ack legality.
    always_comb begin
        rd_valid  = '0;
        ack_therm = 1'b1;
        n_pop     = '0;
        for (int k = 0; k < NumRd; k++) begin
            rd_valid[k] = (count > CW'(k));
            rd_addr[k]  = rd_ptr + AW'(k);
            n_pop       = n_pop + CW'(rd_ack_i[k]);
        end
        for (int k = 1; k < NumRd; k++) begin
            if (rd_ack_i[k] && !rd_ack_i[k-1]) begin
                ack_therm = 1'b0;
            end
        end
        ack_any   = |rd_ack_i;
        ack_legal = ack_therm && ((rd_ack_i & ~rd_valid) == '0);
        pop_en    = ack_any && ack_legal && !flush_i;
        ack_err   = ack_any && !ack_legal && !flush_i;
    end

    // Pointer and occupancy update. Flush takes priority over same-cycle writes and pops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(n_wr);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(n_pop);
            end
            count <= count + (wr_en ? n_wr : CW'(0)) - (pop_en ? n_pop : CW'(0));
        end
    end

    // Sticky protocol error: only reset clears it. Flush does not clear it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            proto_err <= 1'b0;
        end else if (wr_err || ack_err) begin
            proto_err <= 1'b1;
        end
    end

    // Entry storage: one slot per valid write port, written only on an accepted write.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumWr; k++) begin
            if (wr_en && wr_valid_i[k]) begin
                mem_pl[wr_addr[k]] <= wr_pl_i[k*PlW +: PlW];
                mem_pc[wr_addr[k]] <= wr_pc_i[k*32 +: 32];
            end
        end
    end

    // Head window read-out, combinational from the array.
    always_comb begin
        rd_pl_o = '0;
        rd_pc_o = '0;
        for (int k = 0; k < NumRd; k++) begin
            rd_pl_o[k*PlW +: PlW] = mem_pl[rd_addr[k]];
            rd_pc_o[k*32 +: 32]   = mem_pc[rd_addr[k]];
        end
    end

    assign wr_ready_o  = wr_ready;
    assign rd_valid_o  = rd_valid;
    assign count_o     = count;
    assign empty_o     = (count == '0);
    assign full_o      = (count == CW'(Depth));
    assign proto_err_o = proto_err;

endmodule

// File: tb/tb_sbd_fifo_mw.sv
// Directed self-checking bench for sbd_fifo_mw (Depth=8, NumWr=2, NumRd=2, PlW=5).
module tb_sbd_fifo_mw;

    localparam int Depth = 8;
    localparam int NumWr = 2;
    localparam int NumRd = 2;
    localparam int PlW   = 5;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [NumWr-1:0]       wr_valid;
    logic [NumWr*PlW-1:0]   wr_pl;
    logic [NumWr*32-1:0]    wr_pc;
    logic                   wr_ready;
    logic [NumRd-1:0]       rd_valid;
    logic [NumRd*PlW-1:0]   rd_pl;
    logic [NumRd*32-1:0]    rd_pc;
    logic [NumRd-1:0]       rd_ack;
    logic [3:0]             count;
    logic                   empty;
    logic                   full;
    logic                   proto_err;

    int total = 0;
    int bad   = 0;

    sbd_fifo_mw #(.Depth(Depth), .NumWr(NumWr), .NumRd(NumRd), .PlW(PlW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .wr_valid_i  (wr_valid),
        .wr_pl_i     (wr_pl),
        .wr_pc_i     (wr_pc),
        .wr_ready_o  (wr_ready),
        .rd_valid_o  (rd_valid),
        .rd_pl_o     (rd_pl),
        .rd_pc_o     (rd_pc),
        .rd_ack_i    (rd_ack),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .proto_err_o (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush    = 1'b0;
        wr_valid = '0;
        wr_pl    = '0;
        wr_pc    = '0;
        rd_ack   = '0;
    endtask

    task automatic drive_wr(input logic [1:0] v, input logic [4:0] pl0, input logic [31:0] pc0,
                            input logic [4:0] pl1, input logic [31:0] pc1);
        wr_valid = v;
        wr_pl    = {pl1, pl0};
        wr_pc    = {pc1, pc0};
    endtask

    function automatic logic [31:0] spc(input int i);
        return 32'h1000 + 32'(i * 4);
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        #12;
        rst = 1'b0;
        #1;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_proto", 64'(proto_err), 64'd0);

        // Double write goes in, and both entries are visible one cycle later.
        drive_wr(2'b11, 5'b00001, 32'h100, 5'b00100, 32'h104);
        tick();
        idle();
        chk("dw_rd_valid", 64'(rd_valid), 64'd3);
        chk("dw_rd_pc", 64'(rd_pc), {32'h104, 32'h100});
        chk("dw_rd_pl", 64'(rd_pl), 64'({5'b00100, 5'b00001}));
        chk("dw_count", 64'(count), 64'd2);
        rd_ack = 2'b11;
        tick();
        idle();
        chk("dw_drain_count", 64'(count), 64'd0);

        // A port1-only write compacts to the head; a later port0 write follows it.
        drive_wr(2'b10, 5'b0, 32'h0, 5'b01000, 32'h200);
        tick();
        idle();
        chk("p1_rd_valid", 64'(rd_valid), 64'd1);
        chk("p1_head_pc", 64'(rd_pc[31:0]), 64'h200);
        chk("p1_head_pl", 64'(rd_pl[4:0]), 64'(5'b01000));
        drive_wr(2'b01, 5'b10000, 32'h204, 5'b0, 32'h0);
        tick();
        idle();
        chk("p1_rd_valid2", 64'(rd_valid), 64'd3);
        chk("p1_second_pc", 64'(rd_pc[63:32]), 64'h204);
        chk("p1_count", 64'(count), 64'd2);
        rd_ack = 2'b11;
        tick();
        idle();
        chk("p1_proto", 64'(proto_err), 64'd0);

        // Fill to full, then try an over-write, then pop two entries.
        for (int i = 0; i < 4; i++) begin
            drive_wr(2'b11, 5'b00001, 32'h300 + 32'(8 * i), 5'b00010, 32'h304 + 32'(8 * i));
            tick();
        end
        idle();
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_wr_ready", 64'(wr_ready), 64'd0);
        chk("fill_proto_clear", 64'(proto_err), 64'd0);
        drive_wr(2'b01, 5'b00001, 32'h400, 5'b0, 32'h0);
        tick();
        idle();
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_proto", 64'(proto_err), 64'd1);
        chk("ovf_head", 64'(rd_pc), {32'h304, 32'h300});
        rd_ack = 2'b11;
        tick();
        idle();
        chk("pop_count", 64'(count), 64'd6);
        chk("pop_wr_ready", 64'(wr_ready), 64'd1);
        chk("pop_full", 64'(full), 64'd0);
        for (int i = 1; i < 4; i++) begin
            chk("drain_head", 64'(rd_pc), {32'h304 + 32'(8 * i), 32'h300 + 32'(8 * i)});
            rd_ack = 2'b11;
            tick();
            idle();
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // Steady state: preload two entries, then write two and pop two each cycle across several pointer wraps.
        drive_wr(2'b11, 5'b00001, spc(0), 5'b00010, spc(1));
        tick();
        for (int c = 0; c < 20; c++) begin
            chk("ss_head", 64'(rd_pc), {spc(2 * c + 1), spc(2 * c)});
            drive_wr(2'b11, 5'b00100, spc(2 * c + 2), 5'b01000, spc(2 * c + 3));
            rd_ack = 2'b11;
            tick();
            chk("ss_count", 64'(count), 64'd2);
        end
        idle();
        chk("ss_tail", 64'(rd_pc), {spc(41), spc(40)});
        rd_ack = 2'b11;
        tick();
        idle();
        chk("ss_drain", 64'(count), 64'd0);

        // An asynchronous reset clears the sticky flag without waiting for a clock edge.
        rst = 1'b1;
        #2;
        chk("rst2_proto", 64'(proto_err), 64'd0);
        chk("rst2_count", 64'(count), 64'd0);
        rst = 1'b0;

        // Illegal ack 2'b10 pops nothing and sets the sticky error.
        drive_wr(2'b11, 5'b00001, 32'h500, 5'b00010, 32'h504);
        tick();
        idle();
        chk("ill_rd_valid", 64'(rd_valid), 64'd3);
        rd_ack = 2'b10;
        tick();
        idle();
        chk("ill_count", 64'(count), 64'd2);
        chk("ill_proto", 64'(proto_err), 64'd1);
        chk("ill_head", 64'(rd_pc), {32'h504, 32'h500});

        // Build count to 5, then flush alongside a double write and an ack.
        drive_wr(2'b11, 5'b00001, 32'h508, 5'b00010, 32'h50c);
        tick();
        drive_wr(2'b01, 5'b00001, 32'h510, 5'b0, 32'h0);
        tick();
        idle();
        chk("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        drive_wr(2'b11, 5'b00001, 32'h520, 5'b00010, 32'h524);
        rd_ack = 2'b11;
        tick();
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_rd_valid", 64'(rd_valid), 64'd0);
        chk("flush_proto", 64'(proto_err), 64'd1);
        chk("flush_wr_ready", 64'(wr_ready), 64'd1);

        // After a flush, new entries start again from a clean head.
        drive_wr(2'b01, 5'b00100, 32'h600, 5'b0, 32'h0);
        tick();
        idle();
        chk("post_flush_valid", 64'(rd_valid), 64'd1);
        chk("post_flush_pc", 64'(rd_pc[31:0]), 64'h600);
        chk("post_flush_count", 64'(count), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbd_fifo_mw.md
Name: sbd_fifo_mw

Overview:
- Parametrised, multi-port successor to the single-entry-per-cycle scoreboard FIFO.
- Records, in program order, which pipeline (one-hot pl code) each issued instruction went to, plus its PC for debug.
- Accepts up to NumWr issue-slot entries and retires up to NumRd commit-slot entries per cycle.
- Sits between the issue stage and the in-order commit logic; adds flush, occupancy reporting and sticky protocol-error detection.

Parameters:
- Depth, 8, number of entries; power of two, >= 2*max(NumWr,NumRd)
- NumWr, 2, write (issue) ports; 1 or 2
- NumRd, 2, read (commit) ports; 1 or 2
- PlW, 5, width of the pipeline one-hot field

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all entries
- wr_valid_i  in  NumWr  per-port write request
- wr_pl_i  in  NumWr*PlW  pl field, port k at [k*PlW +: PlW]
- wr_pc_i  in  NumWr*32  pc field, port k at [k*32 +: 32]
- wr_ready_o  out  1  at least NumWr free entries
- rd_valid_o  out  NumRd  thermometer; bit k = entry k from head present
- rd_pl_o  out  NumRd*PlW  pl of head+k
- rd_pc_o  out  NumRd*32  pc of head+k
- rd_ack_i  in  NumRd  pop entries; must be thermometer and a subset of rd_valid_o
- count_o  out  $clog2(Depth)+1  occupancy
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == Depth
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_i high, async):
  - rd_ptr, wr_ptr and count clear to 0; proto_err_o clears to 0.
  - Outputs after reset: rd_valid_o = 0, count_o = 0, empty_o = 1, full_o = 0, wr_ready_o = 1.
  - Storage array is not reset; rd_pl_o/rd_pc_o are don't-care while the matching rd_valid_o bit is 0.
- Write:
  - wr_ready_o = (Depth - count) >= NumWr, combinational from registered count.
  - When wr_ready_o = 1, valid ports are compacted in ascending port order. If only port 1 is valid, it is written at wr_ptr.
  - wr_ptr advances by popcount(wr_valid_i), modulo Depth.
  - Writes are all-or-nothing: any wr_valid_i while wr_ready_o = 0 writes nothing and sets proto_err_o.
- Read:
  - rd_valid_o[k] = (count > k); rd_*_o[k] = mem[(rd_ptr + k) mod Depth], combinational from the array.
  - Pops = popcount(rd_ack_i); rd_ptr advances by pops modulo Depth.
  - An illegal ack pattern (not thermometer, e.g. 2'b10, or any bit set where rd_valid_o is 0) pops nothing and sets proto_err_o.
- Latency and bypass:
  - Write-to-read latency is 1 cycle. No bypass: an entry written in cycle N is visible on rd_valid_o in N+1.
- Simultaneous write and read:
  - Both act in the same cycle; count_next = count + writes - pops.
  - A read in the same cycle never frees space for a write; wr_ready_o depends only on the current count.
  - Pointer wrap-around is pure modulo; no extra wrap bit, since occupancy is held in count.
- Flush:
  - flush_i clears rd_ptr, wr_ptr and count on the next edge.
  - flush_i has priority: same-cycle writes and acks are ignored and raise no error.
  - proto_err_o is not cleared by flush.
- proto_err_o: once set, stays 1 until rst_i. It is intended for assertions and debug, not for functional recovery.
- Invariants for the verification bench:
  - count <= Depth always.
  - rd_valid_o is always thermometer.
  - Entries leave in exactly the order they entered.

Test Plan:
- Reset, then write pl=5'b00001/pc=0x100 on port0 and pl=5'b00100/pc=0x104 on port1 in the same cycle -> next cycle rd_valid_o=2'b11, rd_pc_o={0x104,0x100}, count_o=2.
- Write port1 only (pc=0x200) into an empty FIFO -> next cycle rd_valid_o=2'b01, rd_pc_o[0]=0x200; a following port0 write with pc=0x204 appears at head+1.
- Depth=8: fill with 8 entries (4 double writes) -> full_o=1, wr_ready_o=0. A further write leaves count at 8 and sets proto_err_o=1. Acking 2'b11 then drops count to 6 and raises wr_ready_o.
- Steady state: write 2 and ack 2 per cycle for 20 cycles, wrapping pointers -> count_o holds constant and popped pcs match the issue order exactly.
- Illegal ack 2'b10 with rd_valid_o=2'b11 -> no pop, count unchanged, proto_err_o=1 persisting through a later flush_i.
- flush_i asserted in the same cycle as a double write with count=5 -> next cycle count_o=0, empty_o=1, rd_valid_o=0, proto_err_o unchanged.
